// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: hazard FSM states, register index type and latch-control bundles.
package cpu_types_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned STATE_W = 3;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [STATE_W-1:0] {
    RUN    = 3'd0,
    BUBBLE = 3'd1,
    DWAIT  = 3'd2,
    HALT   = 3'd3
  } hazard_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } latch_ctrl_t;

  // Canned latch-control patterns, one per pipeline action
  localparam latch_ctrl_t CTRL_FREEZE   = latch_ctrl_t'(8'b00000_000);
  localparam latch_ctrl_t CTRL_ADVANCE  = latch_ctrl_t'(8'b11111_000);
  localparam latch_ctrl_t CTRL_REDIRECT = latch_ctrl_t'(8'b11111_111);
  localparam latch_ctrl_t CTRL_STALL    = latch_ctrl_t'(8'b00111_010);
  localparam latch_ctrl_t CTRL_IMISS    = latch_ctrl_t'(8'b01111_100);
  localparam latch_ctrl_t CTRL_HALTING  = latch_ctrl_t'(8'b00001_000);

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake and latch-control bundle between the hazard controller and the datapath.
interface pipeline_hazard_ctrl_if;
  import cpu_types_pkg::*;

  logic     ihit;
  logic     dhit;
  logic     dmem_req;
  logic     ex_load;
  regbits_t ex_rw;
  regbits_t id_rs;
  regbits_t id_rt;
  logic     id_uses_rt;
  logic     redirect_mem;
  logic     halt_mem;

  logic     pc_en;
  logic     ifid_en;
  logic     idex_en;
  logic     exmem_en;
  logic     memwb_en;
  logic     ifid_flush;
  logic     idex_flush;
  logic     exmem_flush;
  logic     halted;
  logic     timeout;
  logic [STATE_W-1:0] state_o;

  modport hc (
    input  ihit, dhit, dmem_req, ex_load, ex_rw, id_rs, id_rt, id_uses_rt,
           redirect_mem, halt_mem,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, timeout, state_o
  );

  modport tb (
    output ihit, dhit, dmem_req, ex_load, ex_rw, id_rs, id_rt, id_uses_rt,
           redirect_mem, halt_mem,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, timeout, state_o
  );

endinterface

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_load,
  input  regbits_t ex_rw,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  input  logic     id_uses_rt,
  output logic     hazard
);

  assign hazard = ex_load && (ex_rw != '0) &&
                  ((ex_rw == id_rs) || (id_uses_rt && (ex_rw == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: turns cache handshakes, redirects, load-use hazards and halt
// into PC/latch enables and flushes for the 5-stage pipeline.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned WAIT_MAX   = 255
) (
  input logic              CLK,
  input logic              nRST,
  pipeline_hazard_ctrl_if.hc hc
);

  localparam int unsigned BUB_W  = 3;
  localparam int unsigned WAIT_W = 8;
  localparam logic [BUB_W-1:0]  BUB_LAST = BUB_W'(LU_BUBBLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  hazard_state_t     state_q, state_d, run_state;
  logic [BUB_W-1:0]  bub_cnt_q, bub_cnt_d, run_bub;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic              hazard, dmem_wait, halted_c;
  latch_ctrl_t       ctrl, run_ctrl;

  load_use_detect u_load_use_detect (
    .ex_load    (hc.ex_load),
    .ex_rw      (hc.ex_rw),
    .id_rs      (hc.id_rs),
    .id_rt      (hc.id_rt),
    .id_uses_rt (hc.id_uses_rt),
    .hazard     (hazard)
  );

  assign dmem_wait = hc.dmem_req && !hc.dhit;

  // Lower-priority rules shared by RUN and the DWAIT release cycle
  always_comb begin
    run_ctrl  = CTRL_ADVANCE;
    run_state = RUN;
    run_bub   = '0;
    if (hc.redirect_mem) begin
      run_ctrl = CTRL_REDIRECT;
    end else if (hazard) begin
      run_ctrl = CTRL_STALL;
      if (LU_BUBBLES > 1) begin
        run_state = BUBBLE;
        run_bub   = BUB_W'(1);
      end
    end else if (!hc.ihit) begin
      run_ctrl = CTRL_IMISS;
    end
  end

  always_comb begin
    ctrl       = CTRL_FREEZE;
    halted_c   = 1'b0;
    state_d    = state_q;
    bub_cnt_d  = bub_cnt_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (hc.halt_mem) begin
          ctrl    = CTRL_HALTING;
          state_d = HALT;
        end else if (dmem_wait) begin
          state_d    = DWAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          ctrl      = run_ctrl;
          state_d   = run_state;
          bub_cnt_d = run_bub;
        end
      end
      BUBBLE: begin
        if (hc.halt_mem) begin
          ctrl    = CTRL_HALTING;
          state_d = HALT;
        end else if (dmem_wait) begin
          state_d    = DWAIT;
          wait_cnt_d = WAIT_W'(1);
          bub_cnt_d  = '0;
        end else if (hc.redirect_mem) begin
          ctrl      = CTRL_REDIRECT;
          state_d   = RUN;
          bub_cnt_d = '0;
        end else begin
          ctrl = CTRL_STALL;
          if (bub_cnt_q == BUB_LAST) begin
            state_d   = RUN;
            bub_cnt_d = '0;
          end else begin
            bub_cnt_d = bub_cnt_q + BUB_W'(1);
          end
        end
      end
      DWAIT: begin
        if (hc.halt_mem) begin
          ctrl    = CTRL_HALTING;
          state_d = HALT;
        end else if (!hc.dhit) begin
          wait_cnt_d = (wait_cnt_q >= WAIT_LIM) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        end else begin
          ctrl       = run_ctrl;
          state_d    = run_state;
          bub_cnt_d  = run_bub;
          wait_cnt_d = '0;
        end
      end
      HALT: begin
        halted_c = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    // wait_cnt only reaches the limit inside a dmem wait, so this is the timeout event
    timeout_d = timeout_q || (wait_cnt_d == WAIT_LIM);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= RUN;
      bub_cnt_q  <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bub_cnt_q  <= bub_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Everything is held quiet while reset is asserted
  assign hc.pc_en       = nRST && ctrl.pc_en;
  assign hc.ifid_en     = nRST && ctrl.ifid_en;
  assign hc.idex_en     = nRST && ctrl.idex_en;
  assign hc.exmem_en    = nRST && ctrl.exmem_en;
  assign hc.memwb_en    = nRST && ctrl.memwb_en;
  assign hc.ifid_flush  = nRST && ctrl.ifid_flush;
  assign hc.idex_flush  = nRST && ctrl.idex_flush;
  assign hc.exmem_flush = nRST && ctrl.exmem_flush;
  assign hc.halted      = nRST && halted_c;
  assign hc.timeout     = timeout_q;
  assign hc.state_o     = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios then randomized traffic,
// checked cycle by cycle against a behavioural model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned LU  = 2;
  localparam int unsigned WMX = 4;

  localparam int M_RUN = 0, M_BUBBLE = 1, M_DWAIT = 2, M_HALT = 3;

  // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl}
  localparam logic [7:0] C_NONE  = 8'b00000_000;
  localparam logic [7:0] C_ALL   = 8'b11111_000;
  localparam logic [7:0] C_REDIR = 8'b11111_111;
  localparam logic [7:0] C_STALL = 8'b00111_010;
  localparam logic [7:0] C_IMISS = 8'b01111_100;
  localparam logic [7:0] C_HALT  = 8'b00001_000;

  typedef struct packed {
    logic       nrst;
    logic       ihit;
    logic       dhit;
    logic       dmem_req;
    logic       ex_load;
    logic [4:0] ex_rw;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       redirect;
    logic       halt;
  } stim_t;

  typedef struct packed {
    int          cyc;
    logic [12:0] v;
  } exp_t;

  logic clk;
  logic nrst;
  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.LU_BUBBLES(LU), .WAIT_MAX(WMX)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .hc   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  int m_mode     = M_RUN;
  int m_bub_left = 0;
  int m_waited   = 0;
  bit m_to       = 1'b0;

  function automatic stim_t idle();
    stim_t s = '0;
    s.nrst = 1'b1;
    s.ihit = 1'b1;
    return s;
  endfunction

  // Behavioural model: what the pipeline must see this cycle, then advance the model
  task automatic model_step(input stim_t s);
    logic [7:0] c   = C_NONE;
    logic       h   = 1'b0;
    logic [2:0] st  = 3'(m_mode);
    logic       ton = m_to;
    logic       hz;
    exp_t       e;
    hz = s.ex_load && (s.ex_rw != 5'd0) &&
         ((s.ex_rw == s.id_rs) || (s.id_uses_rt && (s.ex_rw == s.id_rt)));
    if (!s.nrst) begin
      m_mode = M_RUN; m_bub_left = 0; m_waited = 0; m_to = 1'b0;
    end else if (m_mode == M_HALT) begin
      h = 1'b1;
    end else if (s.halt) begin
      c = C_HALT;
      m_mode = M_HALT;
    end else if (m_mode == M_DWAIT && !s.dhit) begin
      m_waited++;
    end else begin
      if (m_mode == M_DWAIT) begin
        m_mode = M_RUN;
        m_waited = 0;
      end
      if (s.dmem_req && !s.dhit) begin
        m_mode = M_DWAIT; m_waited = 1; m_bub_left = 0;
      end else if (s.redirect) begin
        c = C_REDIR; m_mode = M_RUN; m_bub_left = 0;
      end else if (m_mode == M_BUBBLE) begin
        c = C_STALL;
        m_bub_left--;
        if (m_bub_left == 0) m_mode = M_RUN;
      end else if (hz) begin
        c = C_STALL;
        if (LU > 1) begin
          m_mode = M_BUBBLE;
          m_bub_left = int'(LU) - 1;
        end
      end else if (!s.ihit) begin
        c = C_IMISS;
      end else begin
        c = C_ALL;
      end
    end
    if (m_waited >= int'(WMX)) m_to = 1'b1;
    e.cyc = cyc;
    e.v   = {c, h, ton, st};
    exp_q.push_back(e);
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    cyc++;
    nrst             = s.nrst;
    bus.ihit         = s.ihit;
    bus.dhit         = s.dhit;
    bus.dmem_req     = s.dmem_req;
    bus.ex_load      = s.ex_load;
    bus.ex_rw        = s.ex_rw;
    bus.id_rs        = s.id_rs;
    bus.id_rt        = s.id_rt;
    bus.id_uses_rt   = s.id_uses_rt;
    bus.redirect_mem = s.redirect;
    bus.halt_mem     = s.halt;
    model_step(s);
  endtask

  // Monitor: compare every presented output against the oldest expectation
  initial begin
    exp_t        e;
    logic [12:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
               bus.ifid_flush, bus.idex_flush, bus.exmem_flush,
               bus.halted, bus.timeout, bus.state_o};
        checks++;
        if (act !== e.v) begin
          failures++;
          $display("FAIL ctrl cyc=%0d got=%b required=%b (en5_fl3_halt_to_st3)", e.cyc, act, e.v);
        end
      end
    end
  end

  initial begin
    stim_t s;
    nrst = 1'b0;
    s = idle();
    bus.ihit = 1'b1; bus.dhit = 1'b0; bus.dmem_req = 1'b0; bus.ex_load = 1'b0;
    bus.ex_rw = '0; bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
    bus.redirect_mem = 1'b0; bus.halt_mem = 1'b0;
    @(posedge clk);

    // reset held with ihit, then release
    s = idle(); s.nrst = 1'b0;
    repeat (2) step(s);
    repeat (2) step(idle());

    // load-use on rs, then a load to r0 which must not stall
    s = idle(); s.ex_load = 1'b1; s.ex_rw = 5'd8; s.id_rs = 5'd8;
    repeat (2) step(s);
    step(idle());
    s = idle(); s.ex_load = 1'b1; s.ex_rw = 5'd0; s.id_rs = 5'd0;
    step(s);
    s = idle(); s.ex_load = 1'b1; s.ex_rw = 5'd5; s.id_rt = 5'd5; s.id_uses_rt = 1'b1;
    step(s);
    step(idle());
    step(idle());

    // dmem wait of four cycles, then the hit
    s = idle(); s.dmem_req = 1'b1;
    repeat (4) step(s);
    s.dhit = 1'b1;
    step(s);
    step(idle());

    // redirect beats hazard; dmem wait beats redirect
    s = idle(); s.redirect = 1'b1; s.ex_load = 1'b1; s.ex_rw = 5'd3; s.id_rs = 5'd3;
    step(s);
    s = idle(); s.redirect = 1'b1; s.dmem_req = 1'b1;
    step(s);
    s.dhit = 1'b1;
    step(s);
    s = idle(); s.ihit = 1'b0;
    step(s);

    // timeout: dhit held low past the limit, stays set after the hit
    s = idle(); s.dmem_req = 1'b1;
    repeat (6) step(s);
    s.dhit = 1'b1;
    step(s);
    repeat (2) step(idle());

    // halt, then ignore everything until reset
    s = idle(); s.halt = 1'b1;
    step(s);
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.ihit = 1'($urandom_range(0, 1)); s.dhit = 1'($urandom_range(0, 1));
      s.dmem_req = 1'($urandom_range(0, 1));
      step(s);
    end
    s = idle(); s.nrst = 1'b0;
    step(s);
    step(idle());

    // randomized traffic with small register numbers to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      s.nrst       = ($urandom_range(0, 199) != 0) && !(m_mode == M_HALT && $urandom_range(0, 5) == 0);
      s.ihit       = ($urandom_range(0, 9) < 8);
      s.dhit       = ($urandom_range(0, 9) < 6);
      s.dmem_req   = ($urandom_range(0, 9) < 4);
      s.ex_load    = ($urandom_range(0, 9) < 3);
      s.ex_rw      = 5'($urandom_range(0, 3));
      s.id_rs      = 5'($urandom_range(0, 3));
      s.id_rt      = 5'($urandom_range(0, 3));
      s.id_uses_rt = 1'($urandom_range(0, 1));
      s.redirect   = ($urandom_range(0, 9) == 0);
      s.halt       = ($urandom_range(0, 59) == 0);
      step(s);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
